weight_bias_forward: RTL and testbench
======================================

Name: weight_bias_forward

Overview:
- Forward-path consumer of the packed weight+bias bus that the bias/weight store drives on its BM_WeightBias master port.
- Takes a parent-layer state vector (NP values) and the matching NC×NP weight plus NC bias word.
- Computes NC child activations: y[c] = act(bias[c] + Σp w[p][c]·x[p]), in signed fixed point, with one serial MAC pass over NP.
- Presents the result on a valid/ready master port for the next layer.

Parameters:
- NP, 3, number of parent (input) neurons.
- NC, 2, number of child (output) neurons.
- WF, 8, word width; signed two's complement.
- FRAC, 4, number of fractional bits in every WF word.
- RELU, "yes", "yes" applies ReLU to outputs; "no" passes the saturated value through.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  reset; asynchronous, active-low.
- iValid_AS_WeightBias  in  1  weight/bias word valid.
- oReady_AS_WeightBias  out  1  weight/bias accept.
- iData_AS_WeightBias  in  NC*NP*WF+NC*WF  packed bus: bias[c] at [c*WF +: WF]; w[p][c] at [NC*WF + p*NC*WF + c*WF +: WF].
- iValid_AS_State0  in  1  parent state valid.
- oReady_AS_State0  out  1  parent state accept.
- iData_AS_State0  in  NP*WF  x[p] at [p*WF +: WF].
- oValid_BM_State1  out  1  result valid.
- iReady_BM_State1  in  1  downstream accept.
- oData_BM_State1  out  NC*WF  y[c] at [c*WF +: WF].

Behaviour:
- Reset: one clock; iRST is asynchronous and active-low. While iRST is low: state=IDLE, p counter=0, accumulators=0, oValid_BM_State1=0, oData_BM_State1=0, both oReady=1.
- State machine IDLE → ACC → OUT → IDLE.
- IDLE:
  - Both oReady are high.
  - Join rule: the transfer edge E0 requires iValid_AS_WeightBias && iValid_AS_State0 in the same cycle.
  - A lone valid is not consumed and waits; the source must hold its data.
  - On E0: latch both buses, set acc[c] = sign-extended bias[c] << FRAC, p=0, go to ACC.
- ACC:
  - Both oReady are low.
  - On each edge: acc[c] += w[p][c]·x[p] (full 2*WF signed product), and p increments. All NC lanes run in parallel.
  - On the NP-th edge after E0 (p = NP-1): register oData[c] = act(sat(acc_final[c] >>> FRAC)), assert oValid, go to OUT.
  - Latency: oValid is high in the cycle following edge E0+NP.
- Arithmetic:
  - Accumulator width WA = 2*WF + clog2(NP+1).
  - The shift is arithmetic, i.e. floor rounding.
  - sat clamps to [-2^(WF-1), 2^(WF-1)-1].
  - ReLU maps negative values to 0.
- OUT:
  - oValid and oData are held stable until iReady_BM_State1 is high.
  - On the handshake edge: oValid=0, go to IDLE; readies rise in the next cycle.
  - There is no overlap: new inputs are never accepted in OUT. Throughput is one result per NP+2 cycles at best.
- Input valids in ACC/OUT are ignored (not consumed).
- Reset mid-ACC or mid-OUT: the operation is aborted and discarded, and no stale oValid is produced after release.
- NP=1: ACC lasts exactly one edge.

Decomposition:
- Shared package holds:
  - fixed-point constants (WF, FRAC defaults);
  - the WA width function;
  - the saturate function;
  - the ReLU function;
  - bus-slice index helpers for the weight/bias layout, shared with the bias/weight store.
- One sub-module is natural: weight_bias_mac_lane, a single-child accumulator.
  - Ports: clear/load-bias, enable, weight, state.
  - Outputs: activated WF result.
  - Instantiated NC times.
- The FSM and p counter stay in the top level.

Test Plan:
- Nominal: NP=3, NC=2, FRAC=4; x={30,20,10} raw for p=2,1,0; w[p][c]=p*NC+c; bias[c]=c; both valids together, iReady=1 → oValid one cycle after edge E0+3; y0=0x0A (160>>4), y1=0x0E (236>>4=14).
- Join: assert State0 valid 4 cycles before WeightBias valid → nothing consumed until both are high; result identical to the nominal case.
- Saturation: all x=127, all w=127, bias=0 → 48387>>4 → y=0x7F on both lanes. Negative saturation with RELU="no": x=127, w=-128 → y=0x80.
- ReLU: all w=0xF0 (-16), x=16, bias=0 → acc -768, y=-48 → RELU="yes" gives 0x00; RELU="no" gives 0xD0.
- Backpressure: iReady_BM_State1 low for 5 cycles in OUT → oValid and oData stable; inputs re-presented in OUT are not consumed; readies return one cycle after the handshake.
- Reset mid-ACC: drop iRST after edge E1 → oValid=0 and readies=1 immediately (asynchronously); the next transaction yields the nominal values.

Source files
------------

// File: rtl/weight_bias_forward_pkg.sv
// Shared fixed-point helpers for the weight/bias forward path: widths,
// saturation, activation and the packed weight/bias bus layout.
package weight_bias_forward_pkg;

  localparam int unsigned WF_DEF   = 8;
  localparam int unsigned FRAC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } fwdState_t;

  // Accumulator headroom: full product width plus log2 of the term count.
  function automatic int unsigned accWidth(input int unsigned np, input int unsigned wf);
    return 2 * wf + $clog2(np + 1);
  endfunction

  function automatic longint saturate(input longint v, input int unsigned wf);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (wf - 1)) - 1;
    lo = -(longint'(1) <<< (wf - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint reluAct(input longint v, input bit en);
    return (en && (v < 0)) ? longint'(0) : v;
  endfunction

  function automatic int unsigned biasLsb(input int unsigned c, input int unsigned wf);
    return c * wf;
  endfunction

  function automatic int unsigned weightLsb(input int unsigned p, input int unsigned c,
                                            input int unsigned nc, input int unsigned wf);
    return nc * wf + p * nc * wf + c * wf;
  endfunction

endpackage

// File: rtl/weight_bias_forward_if.sv
// Handshake/bus bundle for weight_bias_forward: weight/bias and parent-state
// sinks plus the child-state result source.
interface weight_bias_forward_if #(
  parameter int unsigned NP = 3,
  parameter int unsigned NC = 2,
  parameter int unsigned WF = 8
);
  logic                      iValid_AS_WeightBias;
  logic                      oReady_AS_WeightBias;
  logic [NC*NP*WF+NC*WF-1:0] iData_AS_WeightBias;
  logic                      iValid_AS_State0;
  logic                      oReady_AS_State0;
  logic [NP*WF-1:0]          iData_AS_State0;
  logic                      oValid_BM_State1;
  logic                      iReady_BM_State1;
  logic [NC*WF-1:0]          oData_BM_State1;

  modport slave (
    input  iValid_AS_WeightBias, iData_AS_WeightBias,
    input  iValid_AS_State0, iData_AS_State0,
    input  iReady_BM_State1,
    output oReady_AS_WeightBias, oReady_AS_State0,
    output oValid_BM_State1, oData_BM_State1
  );

  modport master (
    output iValid_AS_WeightBias, iData_AS_WeightBias,
    output iValid_AS_State0, iData_AS_State0,
    output iReady_BM_State1,
    input  oReady_AS_WeightBias, oReady_AS_State0,
    input  oValid_BM_State1, oData_BM_State1
  );
endinterface

// File: rtl/weight_bias_forward_mac_lane.sv
// One child neuron: bias-preloaded accumulator with a serial signed MAC and
// the activated, saturated result of the accumulation in progress.
module weight_bias_mac_lane
  import weight_bias_forward_pkg::*;
#(
  parameter int unsigned WF      = WF_DEF,
  parameter int unsigned FRAC    = FRAC_DEF,
  parameter int unsigned WA      = 18,
  parameter bit          RELU_EN = 1'b1
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 load,
  input  logic                 en,
  input  logic signed [WF-1:0] bias,
  input  logic signed [WF-1:0] weight,
  input  logic signed [WF-1:0] state,
  output logic        [WF-1:0] actNext
);

  logic signed [WA-1:0]   acc;
  logic signed [WA-1:0]   accSum;
  logic signed [WA-1:0]   biasExt;
  logic signed [WA-1:0]   shifted;
  logic signed [2*WF-1:0] prod;

  always_comb begin
    prod    = weight * state;
    accSum  = acc + {{(WA-2*WF){prod[2*WF-1]}}, prod};
    biasExt = {{(WA-WF){bias[WF-1]}}, bias};
    shifted = accSum >>> FRAC;
    // Result reflects acc after this cycle's term, so the top can register it on the last MAC edge.
    actNext = WF'(reluAct(saturate(longint'(shifted), WF), RELU_EN));
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      acc <= '0;
    end else if (load) begin
      acc <= biasExt <<< FRAC;
    end else if (en) begin
      acc <= accSum;
    end
  end

endmodule

// File: rtl/weight_bias_forward.sv
// Forward layer: joins a weight/bias word with a parent state vector, runs one
// serial MAC pass over the parents on NC parallel lanes, then offers the result.
module weight_bias_forward
  import weight_bias_forward_pkg::*;
#(
  parameter int unsigned NP   = 3,
  parameter int unsigned NC   = 2,
  parameter int unsigned WF   = WF_DEF,
  parameter int unsigned FRAC = FRAC_DEF,
  parameter string       RELU = "yes"
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  weight_bias_forward_if.slave  bus
);

  localparam int unsigned WA      = accWidth(NP, WF);
  localparam int unsigned PW      = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned WBW     = NC*NP*WF + NC*WF;
  localparam bit          RELU_EN = (RELU == "yes");

  fwdState_t state, stateNext;

  logic [PW-1:0]       pCnt;
  logic [WBW-1:0]      wbReg;
  logic [NP*WF-1:0]    xReg;
  logic [NC*WF-1:0]    oDataReg;
  logic                oValidReg;
  logic                load;
  logic                en;
  logic                lastMac;
  logic signed [WF-1:0] xSel;
  logic signed [WF-1:0] wSel [NC];
  logic        [WF-1:0] yNext [NC];

  assign bus.oReady_AS_WeightBias = (state == IDLE);
  assign bus.oReady_AS_State0     = (state == IDLE);
  assign bus.oValid_BM_State1     = oValidReg;
  assign bus.oData_BM_State1      = oDataReg;

  always_comb begin
    xSel = '0;
    for (int unsigned c = 0; c < NC; c++) wSel[c] = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      if (pCnt == PW'(p)) begin
        xSel = xReg[p*WF +: WF];
        for (int unsigned c = 0; c < NC; c++) begin
          wSel[c] = wbReg[weightLsb(p, c, NC, WF) +: WF];
        end
      end
    end
  end

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    en        = 1'b0;
    lastMac   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iValid_AS_WeightBias && bus.iValid_AS_State0) begin
          load      = 1'b1;
          stateNext = ACC;
        end
      end
      ACC: begin
        en = 1'b1;
        if (pCnt == PW'(NP - 1)) begin
          lastMac   = 1'b1;
          stateNext = OUT;
        end
      end
      OUT: begin
        if (bus.iReady_BM_State1) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state     <= IDLE;
      pCnt      <= '0;
      wbReg     <= '0;
      xReg      <= '0;
      oValidReg <= 1'b0;
      oDataReg  <= '0;
    end else begin
      state <= stateNext;
      if (load) begin
        pCnt  <= '0;
        wbReg <= bus.iData_AS_WeightBias;
        xReg  <= bus.iData_AS_State0;
      end else if (en) begin
        pCnt <= lastMac ? '0 : pCnt + PW'(1);
      end
      if (lastMac) begin
        oValidReg <= 1'b1;
        for (int unsigned c = 0; c < NC; c++) oDataReg[c*WF +: WF] <= yNext[c];
      end else if ((state == OUT) && bus.iReady_BM_State1) begin
        oValidReg <= 1'b0;
      end
    end
  end

  // Bias comes straight off the bus: the lane preloads on the same edge the bus is latched.
  for (genvar c = 0; c < NC; c++) begin : gLane
    weight_bias_mac_lane #(
      .WF      (WF),
      .FRAC    (FRAC),
      .WA      (WA),
      .RELU_EN (RELU_EN)
    ) uLane (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .load    (load),
      .en      (en),
      .bias    (bus.iData_AS_WeightBias[biasLsb(c, WF) +: WF]),
      .weight  (wSel[c]),
      .state   (xSel),
      .actNext (yNext[c])
    );
  end

endmodule

// File: tb/tb_weight_bias_forward.sv
// Bench for weight_bias_forward: ReLU and pass-through instances driven in
// lockstep and compared against an integer reference of the layer equation.
module tb_weight_bias_forward;

  localparam int NP   = 3;
  localparam int NC   = 2;
  localparam int WF   = 8;
  localparam int FRAC = 4;
  localparam int WBW  = NC*NP*WF + NC*WF;
  localparam int XW   = NP*WF;
  localparam int YW   = NC*WF;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  always #5 iCLK = ~iCLK;

  weight_bias_forward_if #(.NP(NP), .NC(NC), .WF(WF)) ifY ();
  weight_bias_forward_if #(.NP(NP), .NC(NC), .WF(WF)) ifN ();

  weight_bias_forward #(.NP(NP), .NC(NC), .WF(WF), .FRAC(FRAC), .RELU("yes")) dutY (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (ifY)
  );

  weight_bias_forward #(.NP(NP), .NC(NC), .WF(WF), .FRAC(FRAC), .RELU("no")) dutN (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (ifN)
  );

  int nPass   = 0;
  int nChecks = 0;
  int bias [NC];
  int w    [NP][NC];
  int x    [NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [WBW-1:0] packWB();
    logic [WBW-1:0] v;
    int t;
    v = '0;
    for (int c = 0; c < NC; c++) begin
      t = bias[c];
      v[c*WF +: WF] = t[WF-1:0];
      for (int p = 0; p < NP; p++) begin
        t = w[p][c];
        v[NC*WF + p*NC*WF + c*WF +: WF] = t[WF-1:0];
      end
    end
    return v;
  endfunction

  function automatic logic [XW-1:0] packX();
    logic [XW-1:0] v;
    int t;
    v = '0;
    for (int p = 0; p < NP; p++) begin
      t = x[p];
      v[p*WF +: WF] = t[WF-1:0];
    end
    return v;
  endfunction

  // Layer equation in plain integers: y = act(clamp(floor((bias*2^F + sum w*x) / 2^F))).
  function automatic int model(input int c, input bit reluEn);
    int acc;
    int s;
    acc = bias[c] * (1 << FRAC);
    for (int p = 0; p < NP; p++) acc += w[p][c] * x[p];
    s = acc >>> FRAC;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (reluEn && s < 0) s = 0;
    return s & 255;
  endfunction

  function automatic logic [YW-1:0] expY(input bit reluEn);
    logic [YW-1:0] v;
    int t;
    for (int c = 0; c < NC; c++) begin
      t = model(c, reluEn);
      v[c*WF +: WF] = t[WF-1:0];
    end
    return v;
  endfunction

  task automatic setIn(input bit vWB, input bit vX);
    ifY.iValid_AS_WeightBias = vWB;
    ifN.iValid_AS_WeightBias = vWB;
    ifY.iValid_AS_State0     = vX;
    ifN.iValid_AS_State0     = vX;
    ifY.iData_AS_WeightBias  = packWB();
    ifN.iData_AS_WeightBias  = packWB();
    ifY.iData_AS_State0      = packX();
    ifN.iData_AS_State0      = packX();
  endtask

  task automatic setReady(input bit r);
    ifY.iReady_BM_State1 = r;
    ifN.iReady_BM_State1 = r;
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic transact(input string tag, input int preX, input int hold,
                          input bit useFix, input logic [YW-1:0] fixY, input logic [YW-1:0] fixN);
    logic [YW-1:0] eY;
    logic [YW-1:0] eN;
    int lat;
    eY = useFix ? fixY : expY(1'b1);
    eN = useFix ? fixN : expY(1'b0);
    setReady(1'b0);
    if (preX > 0) begin
      setIn(1'b0, 1'b1);
      repeat (preX) tick();
      chk({tag, "/joinWait"},
          {ifY.oReady_AS_WeightBias, ifY.oReady_AS_State0, ifN.oReady_AS_State0, ifY.oValid_BM_State1},
          4'b1110);
    end
    setIn(1'b1, 1'b1);
    tick();
    setIn(1'b0, 1'b0);
    chk({tag, "/accReady"},
        {ifY.oReady_AS_WeightBias, ifY.oReady_AS_State0, ifN.oReady_AS_WeightBias, ifN.oReady_AS_State0},
        4'b0000);
    lat = 0;
    while (!ifY.oValid_BM_State1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "/latency"}, lat, NP);
    chk({tag, "/validN"}, ifN.oValid_BM_State1, 1'b1);
    chk({tag, "/dataRelu"}, ifY.oData_BM_State1, eY);
    chk({tag, "/dataPass"}, ifN.oData_BM_State1, eN);
    if (hold > 0) begin
      setIn(1'b1, 1'b1);
      for (int i = 0; i < hold; i++) begin
        tick();
        chk({tag, "/holdCtl"},
            {ifY.oValid_BM_State1, ifN.oValid_BM_State1, ifY.oReady_AS_WeightBias, ifN.oReady_AS_State0},
            4'b1100);
        chk({tag, "/holdData"}, {ifY.oData_BM_State1, ifN.oData_BM_State1}, {eY, eN});
      end
      setIn(1'b0, 1'b0);
    end
    setReady(1'b1);
    tick();
    setReady(1'b0);
    chk({tag, "/handshake"},
        {ifY.oValid_BM_State1, ifN.oValid_BM_State1, ifY.oReady_AS_WeightBias, ifN.oReady_AS_State0},
        4'b0011);
  endtask

  task automatic loadNominal();
    for (int p = 0; p < NP; p++) x[p] = 10 * (p + 1);
    for (int c = 0; c < NC; c++) begin
      bias[c] = c;
      for (int p = 0; p < NP; p++) w[p][c] = p * NC + c;
    end
  endtask

  task automatic loadUniform(input int bv, input int wv, input int xv);
    for (int p = 0; p < NP; p++) x[p] = xv;
    for (int c = 0; c < NC; c++) begin
      bias[c] = bv;
      for (int p = 0; p < NP; p++) w[p][c] = wv;
    end
  endtask

  initial begin
    loadNominal();
    setIn(1'b0, 1'b0);
    setReady(1'b0);
    #2 iRST = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    chk("reset/ctl",
        {ifY.oValid_BM_State1, ifN.oValid_BM_State1, ifY.oReady_AS_WeightBias,
         ifY.oReady_AS_State0, ifN.oReady_AS_WeightBias, ifN.oReady_AS_State0},
        6'b001111);
    chk("reset/data", {ifY.oData_BM_State1, ifN.oData_BM_State1}, 32'h0);
    @(negedge iCLK) iRST = 1'b1;
    tick();

    loadNominal();
    transact("nominal", 0, 0, 1'b1, 16'h0E0A, 16'h0E0A);
    transact("join", 4, 0, 1'b1, 16'h0E0A, 16'h0E0A);

    loadUniform(0, 127, 127);
    transact("satPos", 0, 0, 1'b1, 16'h7F7F, 16'h7F7F);
    loadUniform(0, -128, 127);
    transact("satNeg", 0, 0, 1'b1, 16'h0000, 16'h8080);
    loadUniform(0, -16, 16);
    transact("relu", 0, 0, 1'b1, 16'h0000, 16'hD0D0);

    loadNominal();
    transact("backpressure", 0, 5, 1'b1, 16'h0E0A, 16'h0E0A);

    // Abort one MAC edge into the pass.
    loadNominal();
    setReady(1'b1);
    setIn(1'b1, 1'b1);
    tick();
    setIn(1'b0, 1'b0);
    @(posedge iCLK);
    #2 iRST = 1'b0;
    #1;
    chk("abort/async",
        {ifY.oValid_BM_State1, ifN.oValid_BM_State1, ifY.oReady_AS_WeightBias, ifN.oReady_AS_State0},
        4'b0011);
    repeat (2) @(posedge iCLK);
    @(negedge iCLK) iRST = 1'b1;
    repeat (NP + 2) tick();
    chk("abort/noStale", {ifY.oValid_BM_State1, ifN.oValid_BM_State1}, 2'b00);
    setReady(1'b0);
    transact("afterAbort", 0, 0, 1'b1, 16'h0E0A, 16'h0E0A);

    for (int n = 0; n < 10; n++) begin
      for (int p = 0; p < NP; p++) x[p] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < NC; c++) begin
        bias[c] = int'($urandom_range(0, 255)) - 128;
        for (int p = 0; p < NP; p++) w[p][c] = int'($urandom_range(0, 255)) - 128;
      end
      transact($sformatf("rand%0d", n), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
               1'b0, '0, '0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
